vga_fb_scanout: RTL and testbench
=================================

Name: vga_fb_scanout

Overview:
- Downstream consumer of the display state sequencer's pixel-write stream (CounterX, CounterY, color).
- Stores writes into a 160x120x12-bit frame buffer.
- Continuously scans the buffer out as 640x480@60 VGA timing, with 4x pixel replication in both axes.
- clk is the 25 MHz pixel clock: one pixel per clk cycle.

Parameters:
- H_VIS, 640, visible pixels per line
- H_FP, 16, horizontal front porch
- H_SYNC, 96, hsync pulse width
- H_BP, 48, horizontal back porch
- V_VIS, 480, visible lines
- V_FP, 10, vertical front porch
- V_SYNC, 2, vsync pulse width
- V_BP, 33, vertical back porch
- FB_W, 160, frame buffer width
- FB_H, 120, frame buffer height
- SCALE_SH, 2, log2 of replication factor

Ports:
- clk  in  1  pixel clock, all logic on posedge
- rst  in  1  reset
- wr_en  in  1  pixel write strobe
- wr_x  in  8  write column (CounterX)
- wr_y  in  8  write row (CounterY)
- wr_color  in  12  write colour {R[11:8],G[7:4],B[3:0]}
- vga_r  out  4  red
- vga_g  out  4  green
- vga_b  out  4  blue
- vga_hsync  out  1  horizontal sync, active low
- vga_vsync  out  1  vertical sync, active low
- frame_start  out  1  one-cycle pulse, first visible pixel of a frame on outputs
- wr_drop  out  1  one-cycle pulse, out-of-range write rejected

Behaviour:
- Clocking/reset: one clock, clk. Reset rst is synchronous and active-high.
- Reset values:
  - h_cnt = 0, v_cnt = 0.
  - vga_r/g/b = 0, vga_hsync = 1, vga_vsync = 1.
  - frame_start = 0, wr_drop = 0.
  - Pipeline registers are cleared.
  - Frame buffer contents are NOT cleared; clearing is the upstream sequencer's job.
- Counters:
  - h_cnt runs 0..799 and wraps to 0.
  - v_cnt increments when h_cnt wraps, runs 0..524, and wraps to 0.
  - The first cycle after rst deasserts has (h,v) = (0,0).
- Sync, evaluated on counter values:
  - hsync_n = 0 iff 656 <= h_cnt <= 751.
  - vsync_n = 0 iff 490 <= v_cnt <= 491.
  - visible iff h_cnt < 640 and v_cnt < 480.
- Read address:
  - rd_addr = (v_cnt >> 2) * 160 + (h_cnt >> 2), 15-bit, range 0..19199.
  - Computed combinationally from the counters; only used when visible.
- Pipeline, 2-cycle latency:
  - Cycle t: counters at (h,v), RAM read issued.
  - Cycle t+1: RAM data registered; sync and visible delayed one stage.
  - Cycle t+2: output registers drive vga_* for (h,v).
  - vga_r/g/b = RAM data when delayed visible = 1, else 0.
  - Sync outputs carry the same 2-cycle delay, so colour and sync stay aligned.
- frame_start is high on the output cycle corresponding to (h,v) = (0,0), i.e. counters at (0,0) plus 2 cycles.
- Write port:
  - Single-cycle, no backpressure; a write is accepted every cycle wr_en = 1.
  - In range (wr_x < 160 and wr_y < 120): wr_addr = wr_y*160 + wr_x; memory is updated at the clock edge.
  - Out of range: no memory change; wr_drop = 1 on the following cycle.
  - wr_en = 0: no effect, wr_drop = 0.
- Simultaneous read and write to the same address: read-first. The scanout sees the old value that cycle; the new value is visible from the next read of that address.
- Writes during rst = 1 are ignored.
- Reset mid-frame: counters return to (0,0) on the next cycle and outputs take their reset values. The output pipeline refills, and frame_start fires 2 cycles after the first post-reset (0,0). No partial-frame state survives.
- Arithmetic:
  - Multiply by 160 is implemented as (y<<7)+(y<<5).
  - All address math is 15-bit unsigned; there is no overflow for in-range inputs.
- Memory: 19200 x 12, one write port and one read port, inferable as block RAM.

Test Plan:
- Reset/timing:
  - Assert rst 3 cycles, release.
  - Expect hsync=1, vsync=1, rgb=0 during reset.
  - Expect hsync low for 96 cycles every 800; first fall at cycle 658 after release.
  - Expect vsync low for 1600 cycles every 420000; frame_start period 420000.
- Basic write/replicate:
  - Write (0,0)=0xF00, then (1,0)=0x0F0.
  - At next frame, line 0: pixels 0-3 = r=F; pixels 4-7 = g=F; pixel 8 = 000.
  - Lines 1-3 are identical to line 0; line 4 pixel 0 = 000.
- Corner:
  - Write (159,119)=0x00F.
  - Pixels 636-639 of lines 476-479 show b=F.
  - Porch cycles (h 640-799) show rgb=0.
- Out of range:
  - Write (160,0)=0xFFF, then (0,120)=0xFFF.
  - wr_drop pulses once per write; the frame shows no change.
  - Valid writes on other cycles give wr_drop=0.
- Read/write collision:
  - Write 0x123 to address 0 in the cycle counters are at (0,0).
  - Output at t+2 shows the old value; the next line 1 pixel 0 shows 0x123.
- Mid-frame reset:
  - Assert rst at (h,v)=(300,200) for 1 cycle.
  - Outputs reset, counters restart at (0,0), frame_start 2 cycles after.
  - Previously written pixels remain intact.

Source files
------------

// File: rtl/vga_fb_scanout.sv
// Frame buffer (160x120x12) fed by the sequencer's pixel-write stream and
// scanned out continuously as 640x480@60 VGA with 4x replication in both axes.
module vga_fb_scanout #(
    parameter int H_VIS    = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_VIS    = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter int FB_W     = 160,
    parameter int FB_H     = 120,
    parameter int SCALE_SH = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wr_en,
    input  logic [7:0]  wr_x,
    input  logic [7:0]  wr_y,
    input  logic [11:0] wr_color,
    output logic [3:0]  vga_r,
    output logic [3:0]  vga_g,
    output logic [3:0]  vga_b,
    output logic        vga_hsync,
    output logic        vga_vsync,
    output logic        frame_start,
    output logic        wr_drop
);
    localparam int H_TOTAL  = H_VIS + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL  = V_VIS + V_FP + V_SYNC + V_BP;
    localparam int FB_DEPTH = FB_W * FB_H;

    localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_VIS_L  = 10'(H_VIS);
    localparam logic [9:0] V_VIS_L  = 10'(V_VIS);
    localparam logic [9:0] HS_FIRST = 10'(H_VIS + H_FP);
    localparam logic [9:0] HS_LAST  = 10'(H_VIS + H_FP + H_SYNC - 1);
    localparam logic [9:0] VS_FIRST = 10'(V_VIS + V_FP);
    localparam logic [9:0] VS_LAST  = 10'(V_VIS + V_FP + V_SYNC - 1);
    localparam logic [7:0] FB_W_L   = 8'(FB_W);
    localparam logic [7:0] FB_H_L   = 8'(FB_H);

    logic [11:0] mem [FB_DEPTH];

    logic [9:0]  h_cnt_q, h_cnt_d;
    logic [9:0]  v_cnt_q, v_cnt_d;
    logic [14:0] rd_row, rd_addr, rd_idx;
    logic [14:0] wr_row, wr_addr;
    logic        wr_in_range;
    logic [11:0] rd_data_q;
    logic        vis1_q, vis1_d;
    logic        hs1_q, hs1_d;
    logic        vs1_q, vs1_d;
    logic        fs1_q, fs1_d;
    logic [11:0] rgb_q, rgb_d;
    logic        hsync_q, hsync_d;
    logic        vsync_q, vsync_d;
    logic        frame_start_q, frame_start_d;
    logic        wr_drop_q, wr_drop_d;

    // Row*160 is built from two shifts, so the address math assumes FB_W = 160.
    always_comb begin
        h_cnt_d = h_cnt_q + 10'd1;
        v_cnt_d = v_cnt_q;
        if (h_cnt_q == H_LAST) begin
            h_cnt_d = '0;
            v_cnt_d = (v_cnt_q == V_LAST) ? '0 : v_cnt_q + 10'd1;
        end

        vis1_d = (h_cnt_q < H_VIS_L) && (v_cnt_q < V_VIS_L);
        hs1_d  = !((h_cnt_q >= HS_FIRST) && (h_cnt_q <= HS_LAST));
        vs1_d  = !((v_cnt_q >= VS_FIRST) && (v_cnt_q <= VS_LAST));
        fs1_d  = (h_cnt_q == '0) && (v_cnt_q == '0);

        rd_row  = 15'(v_cnt_q >> SCALE_SH);
        rd_addr = (rd_row << 7) + (rd_row << 5) + 15'(h_cnt_q >> SCALE_SH);
        rd_idx  = vis1_d ? rd_addr : '0;

        wr_row      = 15'(wr_y);
        wr_addr     = (wr_row << 7) + (wr_row << 5) + 15'(wr_x);
        wr_in_range = (wr_x < FB_W_L) && (wr_y < FB_H_L);
        wr_drop_d   = wr_en && !wr_in_range;

        rgb_d         = vis1_q ? rd_data_q : '0;
        hsync_d       = hs1_q;
        vsync_d       = vs1_q;
        frame_start_d = fs1_q;
    end

    // Sync and visibility ride alongside the RAM read so colour and sync stay aligned.
    always_ff @(posedge clk) begin
        if (rst) begin
            h_cnt_q       <= '0;
            v_cnt_q       <= '0;
            rd_data_q     <= '0;
            vis1_q        <= 1'b0;
            hs1_q         <= 1'b1;
            vs1_q         <= 1'b1;
            fs1_q         <= 1'b0;
            rgb_q         <= '0;
            hsync_q       <= 1'b1;
            vsync_q       <= 1'b1;
            frame_start_q <= 1'b0;
            wr_drop_q     <= 1'b0;
        end else begin
            h_cnt_q       <= h_cnt_d;
            v_cnt_q       <= v_cnt_d;
            rd_data_q     <= mem[rd_idx];
            vis1_q        <= vis1_d;
            hs1_q         <= hs1_d;
            vs1_q         <= vs1_d;
            fs1_q         <= fs1_d;
            rgb_q         <= rgb_d;
            hsync_q       <= hsync_d;
            vsync_q       <= vsync_d;
            frame_start_q <= frame_start_d;
            wr_drop_q     <= wr_drop_d;
        end
    end

    // Buffer contents survive reset; the read above sees the pre-write value.
    always_ff @(posedge clk) begin
        if (!rst && wr_en && wr_in_range) begin
            mem[wr_addr] <= wr_color;
        end
    end

    assign vga_r       = rgb_q[11:8];
    assign vga_g       = rgb_q[7:4];
    assign vga_b       = rgb_q[3:0];
    assign vga_hsync   = hsync_q;
    assign vga_vsync   = vsync_q;
    assign frame_start = frame_start_q;
    assign wr_drop     = wr_drop_q;

endmodule

// File: tb/tb_vga_fb_scanout.sv
// Self-checking bench for vga_fb_scanout: a position-based reference model of
// the scanout plus a second instance with a short vertical frame for vsync timing.
module tb_vga_fb_scanout;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        wr_en = 1'b0;
    logic [7:0]  wr_x = '0;
    logic [7:0]  wr_y = '0;
    logic [11:0] wr_color = '0;

    logic [3:0]  vga_r, vga_g, vga_b;
    logic        vga_hsync, vga_vsync, frame_start, wr_drop;
    logic [3:0]  s_r, s_g, s_b;
    logic        s_hsync, s_vsync, s_fs, s_drop;
    logic [11:0] rgb;

    int n_checks = 0;
    int n_errors = 0;

    localparam int S_VIS  = 8;
    localparam int S_FP   = 2;
    localparam int S_SYNC = 2;
    localparam int S_BP   = 3;

    always #20 clk = ~clk;

    vga_fb_scanout u_dut (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_x(wr_x), .wr_y(wr_y),
        .wr_color(wr_color), .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b),
        .vga_hsync(vga_hsync), .vga_vsync(vga_vsync),
        .frame_start(frame_start), .wr_drop(wr_drop)
    );

    vga_fb_scanout #(.V_VIS(S_VIS), .V_FP(S_FP), .V_SYNC(S_SYNC), .V_BP(S_BP)) u_small (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_x(wr_x), .wr_y(wr_y),
        .wr_color(wr_color), .vga_r(s_r), .vga_g(s_g), .vga_b(s_b),
        .vga_hsync(s_hsync), .vga_vsync(s_vsync),
        .frame_start(s_fs), .wr_drop(s_drop)
    );

    assign rgb = {vga_r, vga_g, vga_b};

    // Reference model: frame position counted from reset release; what is shown
    // now is the pixel addressed two cycles ago, read before that edge's write.
    logic [11:0] fbm [0:19199];
    int          mpos, prev_pos, out_pos;
    logic [11:0] prev_rgb, exp_rgb;
    logic        prev_hs, prev_vs, prev_fs, exp_hs, exp_vs, exp_fs, exp_drop;

    always @(posedge clk) begin
        int h, v;
        if (rst) begin
            mpos <= 0; prev_pos <= -1; out_pos <= -1;
            prev_rgb <= '0; prev_hs <= 1'b1; prev_vs <= 1'b1; prev_fs <= 1'b0;
            exp_rgb <= '0; exp_hs <= 1'b1; exp_vs <= 1'b1; exp_fs <= 1'b0;
            exp_drop <= 1'b0;
        end else begin
            h = mpos % 800;
            v = mpos / 800;
            exp_rgb <= prev_rgb; exp_hs <= prev_hs; exp_vs <= prev_vs; exp_fs <= prev_fs;
            out_pos <= prev_pos;
            prev_rgb <= (h < 640 && v < 480) ? fbm[(v / 4) * 160 + h / 4] : 12'h000;
            prev_hs  <= !(h >= 656 && h < 752);
            prev_vs  <= !(v >= 490 && v < 492);
            prev_fs  <= (h == 0 && v == 0);
            prev_pos <= mpos;
            exp_drop <= wr_en && !(wr_x < 160 && wr_y < 120);
            if (wr_en && wr_x < 160 && wr_y < 120)
                fbm[int'(wr_y) * 160 + int'(wr_x)] <= wr_color;
            mpos <= (mpos + 1) % 420000;
        end
    end

    task automatic do_reset();
        wr_en = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic write_px(input int x, input int y, input logic [11:0] c);
        wr_en = 1'b1; wr_x = 8'(x); wr_y = 8'(y); wr_color = c;
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    task automatic wait_out(input int pos, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 20000; i++) begin
            if (out_pos == pos) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) begin
            @(negedge clk);
            n_checks++;
            if ({vga_hsync, vga_vsync, frame_start, wr_drop, rgb} !== {4'b1100, 12'h000}) begin
                n_errors++;
                $display("[TB] FAIL reset_values got=%b/%b/%b/%b/%h want=1/1/0/0/000",
                         vga_hsync, vga_vsync, frame_start, wr_drop, rgb);
            end
        end
        rst = 1'b0;
        for (int c = 0; c < 3; c++) begin
            n_checks++;
            if (frame_start !== (c == 2)) begin
                n_errors++;
                $display("[TB] FAIL frame_start_after_reset cycle=%0d got=%b want=%b",
                         c, frame_start, c == 2);
            end
            @(negedge clk);
        end
    endtask

    task automatic fill_fb();
        for (int y = 0; y < 16; y++)
            for (int x = 0; x < 160; x++)
                write_px(x, y, 12'($urandom));
    endtask

    task automatic test_basic();
        bit ok;
        logic [11:0] want;
        write_px(0, 0, 12'hF00);
        write_px(1, 0, 12'h0F0);
        write_px(2, 0, 12'h000);
        write_px(0, 1, 12'h000);
        // A write presented during reset must be ignored.
        rst = 1'b1; wr_en = 1'b1; wr_x = 8'd0; wr_y = 8'd0; wr_color = 12'hABC;
        @(negedge clk);
        rst = 1'b0; wr_en = 1'b0;
        for (int line = 0; line < 5; line++) begin
            for (int px = 0; px < 9; px++) begin
                if (line == 4 && px > 0) break;
                want = (line == 4 || px == 8) ? 12'h000 : (px < 4) ? 12'hF00 : 12'h0F0;
                wait_out(line * 800 + px, ok);
                n_checks++;
                if (!ok || rgb !== want) begin
                    n_errors++;
                    $display("[TB] FAIL basic_replicate line=%0d px=%0d got=%h want=%h reached=%0b",
                             line, px, rgb, want, ok);
                end
            end
        end
    endtask

    task automatic test_hsync();
        int   fall1 = -1, fall2 = -1, rise = -1;
        logic last = 1'b1;
        do_reset();
        for (int c = 0; c < 1600; c++) begin
            if (last && !vga_hsync) begin
                if (fall1 < 0) fall1 = c; else if (fall2 < 0) fall2 = c;
            end
            if (!last && vga_hsync && rise < 0) rise = c;
            last = vga_hsync;
            @(negedge clk);
        end
        n_checks++;
        if (fall1 != 658) begin
            n_errors++;
            $display("[TB] FAIL hsync_first_fall got=%0d want=658", fall1);
        end
        n_checks++;
        if (rise - fall1 != 96) begin
            n_errors++;
            $display("[TB] FAIL hsync_width got=%0d want=96", rise - fall1);
        end
        n_checks++;
        if (fall2 - fall1 != 800) begin
            n_errors++;
            $display("[TB] FAIL hsync_period got=%0d want=800", fall2 - fall1);
        end
    endtask

    task automatic test_corner();
        bit ok;
        write_px(159, 3, 12'h00F);
        wr_en = 1'b1; wr_x = 8'd159; wr_y = 8'd119; wr_color = 12'h00F;
        @(negedge clk);
        wr_en = 1'b0;
        n_checks++;
        if (wr_drop !== 1'b0) begin
            n_errors++;
            $display("[TB] FAIL corner_write_accepted got=%b want=0", wr_drop);
        end
        do_reset();
        for (int line = 12; line < 16; line++) begin
            for (int px = 636; px < 640; px++) begin
                wait_out(line * 800 + px, ok);
                n_checks++;
                if (!ok || rgb !== 12'h00F) begin
                    n_errors++;
                    $display("[TB] FAIL corner_pixel line=%0d px=%0d got=%h want=00f", line, px, rgb);
                end
            end
            for (int px = 640; px < 800; px += 53) begin
                wait_out(line * 800 + px, ok);
                n_checks++;
                if (!ok || rgb !== 12'h000) begin
                    n_errors++;
                    $display("[TB] FAIL porch_blank line=%0d h=%0d got=%h want=000", line, px, rgb);
                end
            end
        end
    endtask

    task automatic test_out_of_range();
        bit ok;
        int xs[4] = '{160, 0, 255, 7};
        int ys[4] = '{0, 120, 255, 2};
        for (int i = 0; i < 5; i++) begin
            if (i < 4) begin
                wr_en = 1'b1; wr_x = 8'(xs[i]); wr_y = 8'(ys[i]);
                wr_color = (i == 3) ? 12'h5A5 : 12'hFFF;
            end else begin
                wr_en = 1'b0;
            end
            @(negedge clk);
            n_checks++;
            if (wr_drop !== (i < 3)) begin
                n_errors++;
                $display("[TB] FAIL wr_drop step=%0d got=%b want=%b", i, wr_drop, i < 3);
            end
        end
        do_reset();
        wait_out(4 * 800, ok);
        n_checks++;
        if (!ok || rgb !== 12'h000) begin
            n_errors++;
            $display("[TB] FAIL oor_no_alias got=%h want=000", rgb);
        end
        wait_out(8 * 800 + 28, ok);
        n_checks++;
        if (!ok || rgb !== 12'h5A5) begin
            n_errors++;
            $display("[TB] FAIL valid_write_after_drops got=%h want=5a5", rgb);
        end
    endtask

    task automatic test_collision();
        bit ok;
        write_px(0, 0, 12'h456);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0; wr_en = 1'b1; wr_x = 8'd0; wr_y = 8'd0; wr_color = 12'h123;
        @(negedge clk);
        wr_en = 1'b0;
        @(negedge clk);
        n_checks++;
        if (rgb !== 12'h456) begin
            n_errors++;
            $display("[TB] FAIL collision_old_value got=%h want=456", rgb);
        end
        @(negedge clk);
        n_checks++;
        if (rgb !== 12'h123) begin
            n_errors++;
            $display("[TB] FAIL collision_next_read got=%h want=123", rgb);
        end
        wait_out(800, ok);
        n_checks++;
        if (!ok || rgb !== 12'h123) begin
            n_errors++;
            $display("[TB] FAIL collision_line1 got=%h want=123", rgb);
        end
    endtask

    task automatic test_mid_reset();
        bit ok;
        do_reset();
        wait_out(10 * 800 + 300 - 2, ok);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        for (int c = 0; c < 3; c++) begin
            n_checks++;
            if (!ok || frame_start !== (c == 2) || vga_hsync !== 1'b1 || vga_vsync !== 1'b1 ||
                rgb !== ((c == 2) ? 12'h123 : 12'h000)) begin
                n_errors++;
                $display("[TB] FAIL mid_reset cycle=%0d got fs=%b hs=%b vs=%b rgb=%h reached=%0b",
                         c, frame_start, vga_hsync, vga_vsync, rgb, ok);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_random_scan();
        do_reset();
        for (int c = 0; c < 4000; c++) begin
            if (out_pos >= 0) begin
                n_checks++;
                if (rgb !== exp_rgb || {vga_hsync, vga_vsync, frame_start} !== {exp_hs, exp_vs, exp_fs}) begin
                    n_errors++;
                    $display("[TB] FAIL random_scan pos=%0d got=%h/%b%b%b want=%h/%b%b%b", out_pos,
                             rgb, vga_hsync, vga_vsync, frame_start, exp_rgb, exp_hs, exp_vs, exp_fs);
                end
            end
            n_checks++;
            if (wr_drop !== exp_drop) begin
                n_errors++;
                $display("[TB] FAIL random_drop cycle=%0d got=%b want=%b", c, wr_drop, exp_drop);
            end
            wr_en    = ($urandom_range(0, 3) == 0);
            wr_x     = ($urandom_range(0, 7) == 0) ? 8'($urandom_range(160, 255)) : 8'($urandom_range(0, 159));
            wr_y     = ($urandom_range(0, 7) == 0) ? 8'($urandom_range(120, 255)) : 8'($urandom_range(0, 15));
            wr_color = 12'($urandom);
            @(negedge clk);
        end
        wr_en = 1'b0;
    endtask

    task automatic test_vsync();
        int   fall1 = -1, fall2 = -1, rise = -1, fs1 = -1, fs2 = -1;
        int   frame = (S_VIS + S_FP + S_SYNC + S_BP) * 800;
        logic last = 1'b1;
        do_reset();
        for (int c = 0; c < 20100; c++) begin
            if (last && !s_vsync) begin
                if (fall1 < 0) fall1 = c; else if (fall2 < 0) fall2 = c;
            end
            if (!last && s_vsync && rise < 0) rise = c;
            if (s_fs) begin
                if (fs1 < 0) fs1 = c; else if (fs2 < 0) fs2 = c;
            end
            last = s_vsync;
            @(negedge clk);
        end
        n_checks++;
        if (fall1 != (S_VIS + S_FP) * 800 + 2) begin
            n_errors++;
            $display("[TB] FAIL vsync_first_fall got=%0d want=%0d", fall1, (S_VIS + S_FP) * 800 + 2);
        end
        n_checks++;
        if (rise - fall1 != S_SYNC * 800) begin
            n_errors++;
            $display("[TB] FAIL vsync_width got=%0d want=%0d", rise - fall1, S_SYNC * 800);
        end
        n_checks++;
        if (fall2 - fall1 != frame) begin
            n_errors++;
            $display("[TB] FAIL vsync_period got=%0d want=%0d", fall2 - fall1, frame);
        end
        n_checks++;
        if (fs1 != 2 || fs2 - fs1 != frame) begin
            n_errors++;
            $display("[TB] FAIL frame_start_period got=%0d,%0d want=2,%0d", fs1, fs2, frame + 2);
        end
    endtask

    initial begin
        for (int i = 0; i < 19200; i++) fbm[i] = 12'h000;
        @(negedge clk);
        test_reset();
        fill_fb();
        test_basic();
        test_hsync();
        test_corner();
        test_out_of_range();
        test_collision();
        test_mid_reset();
        test_random_scan();
        test_vsync();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
